y86_exec_ctrl: RTL and testbench
================================

Name: y86_exec_ctrl

Overview:
- Execute-stage controller for the pipelined Y86-64 processor.
- Owns the E pipeline register and the condition-code (CC) register.
- Drives operand and function selection to an external 64-bit ALU and consumes its result and overflow.
- Evaluates branch/cmov conditions and produces the E-stage outputs forwarded to the M stage and to the hazard/forwarding logic.

Parameters:
W, 64, datapath width
REG_NONE, 4'hF, register ID meaning "no destination"

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  synchronous active-low reset
d_icode  input  4  decoded icode from D stage
d_ifun  input  4  decoded ifun
d_valA  input  W  operand A
d_valB  input  W  operand B
d_valC  input  W  constant word
d_dstE  input  4  E-result destination register
d_dstM  input  4  memory-result destination register
d_stat  input  4  status (1=AOK, 2=HLT, 3=ADR, 4=INS)
e_stall  input  1  hold E register
e_bubble  input  1  load nop bubble into E register
m_stat  input  4  status of instruction currently in M
w_stat  input  4  status of instruction currently in W
alu_out  input  W  ALU result
alu_of  input  1  ALU signed overflow
alu_a  output  W  ALU operand A
alu_b  output  W  ALU operand B
alu_fun  output  2  0=add, 1=sub (b-a), 2=and, 3=xor
e_icode  output  4  registered icode
e_valE  output  W  execute result (equals alu_out)
e_valA  output  W  registered valA passthrough
e_dstE  output  4  destination after cmov squash
e_dstM  output  4  registered dstM
e_stat  output  4  registered status
e_cnd  output  1  condition result
cc  output  3  {ZF,SF,OF}, registered

Behaviour:
- Clocking: all state updates on the rising edge of clk; rst_n is sampled only there.
- E register, reset or bubble: icode=1 (nop), ifun=0, valA/valB/valC=0, dstE=dstM=REG_NONE, stat=1.
- E register, rst_n=1, update priority:
  - e_bubble=1: load the bubble values (bubble wins over e_stall).
  - else e_stall=1: hold.
  - else: load all d_* inputs.
- CC reset value: ZF=1, SF=0, OF=0.
- set_cc (combinational) = (E icode==6) && m_stat==1 && w_stat==1 && !e_stall.
- On an edge with set_cc=1 and rst_n=1, CC loads:
  - ZF = (alu_out==0)
  - SF = alu_out[W-1]
  - OF = alu_of
- CC otherwise holds. New flags are visible the cycle after the OPq occupies E. A simultaneous bubble does not block a CC update computed from the current E contents.
- alu_a (combinational from E register):
  - icode 2, 6: valA
  - icode 3, 4, 5: valC
  - icode 8, A: -8
  - icode 9, B: +8
  - otherwise: 0
- alu_b:
  - icode 4, 5, 6, 8, 9, A, B: valB
  - otherwise: 0
- alu_fun = ifun[1:0] when icode==6, else 0.
- All combinational outputs are fully assigned on every path; no latches.
- e_cnd, evaluated only when icode is 2 or 7, otherwise 0:
  - ifun 0: 1
  - ifun 1: (SF^OF)|ZF
  - ifun 2: SF^OF
  - ifun 3: ZF
  - ifun 4: ~ZF
  - ifun 5: ~(SF^OF)
  - ifun 6: ~(SF^OF)&~ZF
  - ifun 7-15: 0
- e_cnd uses the registered CC, never flags being computed in the same cycle.
- e_dstE = REG_NONE when icode==2 && !e_cnd, else the registered dstE.
- e_valE = alu_out. e_valA, e_dstM, e_stat and e_icode are direct register outputs.
- Latency: one cycle from D inputs to E outputs. Outputs derived from alu_out are combinational in the same cycle as the E contents.
- Reset mid-operation: E and CC return to reset values on that edge regardless of e_stall, e_bubble or set_cc.

Test Plan:
- Reset: rst_n=0 for one edge -> e_icode=1, e_dstE=e_dstM=F, e_stat=1, cc=3'b100, e_cnd=0.
- OPq subq: d_icode=6, d_ifun=1, valA=5, valB=3, alu_out=-2 returned -> alu_fun=1, alu_a=5, alu_b=3; next edge cc=3'b010.
- cmovle not taken: cc=3'b000, E holds icode=2, ifun=1, dstE=3 -> e_cnd=0, e_dstE=F. Repeat with cc=3'b100 -> e_cnd=1, e_dstE=3.
- Stall/bubble priority: E holds pushq; e_stall=1 -> E unchanged. e_stall=1 and e_bubble=1 together -> E becomes nop with dstE=F.
- CC suppression: OPq in E with m_stat=3 -> cc unchanged. Same OPq with m_stat=w_stat=1 -> cc updates.
- Stack operand: icode=A, valB=0x100 -> alu_a=-8, alu_b=0x100, alu_fun=0. icode=9 -> alu_a=8.

Source files
------------

// File: rtl/y86_exec_ctrl_if.sv
// ---------------------------------------------------------------------------
// y86_exec_ctrl_if
//   Bundle between the execute-stage controller and the rest of the pipeline.
//   slave  : used by the execute controller
//            (takes in the D-stage fields, stall/bubble, M/W status and the ALU
//            result, and drives the ALU controls, E-stage outputs and CC).
//   master : used by the environment that drives the controller
//            (decode stage, hazard unit, external ALU).
//   Groups:
//     d_*            decoded instruction fields from the D stage
//     e_stall/bubble E pipeline-register control from the hazard unit
//     m_stat/w_stat  status of the instructions further down the pipe
//     alu_*          external ALU operands, function, result and overflow
//     e_*, cc        E-stage outputs and the condition-code register
// ---------------------------------------------------------------------------
interface y86_exec_ctrl_if #(
  parameter int W = 64
);
  logic [3:0]   d_icode;
  logic [3:0]   d_ifun;
  logic [W-1:0] d_valA;
  logic [W-1:0] d_valB;
  logic [W-1:0] d_valC;
  logic [3:0]   d_dstE;
  logic [3:0]   d_dstM;
  logic [3:0]   d_stat;
  logic         e_stall;
  logic         e_bubble;
  logic [3:0]   m_stat;
  logic [3:0]   w_stat;
  logic [W-1:0] alu_out;
  logic         alu_of;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [1:0]   alu_fun;
  logic [3:0]   e_icode;
  logic [W-1:0] e_valE;
  logic [W-1:0] e_valA;
  logic [3:0]   e_dstE;
  logic [3:0]   e_dstM;
  logic [3:0]   e_stat;
  logic         e_cnd;
  logic [2:0]   cc;

  modport slave (
    input  d_icode, d_ifun, d_valA, d_valB, d_valC, d_dstE, d_dstM, d_stat,
    input  e_stall, e_bubble, m_stat, w_stat, alu_out, alu_of,
    output alu_a, alu_b, alu_fun,
    output e_icode, e_valE, e_valA, e_dstE, e_dstM, e_stat, e_cnd, cc
  );

  modport master (
    output d_icode, d_ifun, d_valA, d_valB, d_valC, d_dstE, d_dstM, d_stat,
    output e_stall, e_bubble, m_stat, w_stat, alu_out, alu_of,
    input  alu_a, alu_b, alu_fun,
    input  e_icode, e_valE, e_valA, e_dstE, e_dstM, e_stat, e_cnd, cc
  );
endinterface

// File: rtl/y86_exec_ctrl.sv
// ---------------------------------------------------------------------------
// y86_exec_ctrl
//   Execute-stage controller of the pipelined Y86-64 processor. Holds the E
//   pipeline register and the condition codes, steers the external ALU,
//   evaluates jXX/cmovXX conditions and presents the E-stage results.
//   Ports:
//     clk    rising-edge clock
//     rst_n  synchronous active-low reset
//     bus    y86_exec_ctrl_if.slave (D-stage inputs, hazard controls,
//            ALU interface, E-stage outputs, cc = {ZF,SF,OF})
// ---------------------------------------------------------------------------
module y86_exec_ctrl #(
  parameter int         W        = 64,
  parameter logic [3:0] REG_NONE = 4'hF
) (
  input logic             clk,
  input logic             rst_n,
  y86_exec_ctrl_if.slave  bus
);

  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_CMOV   = 4'h2;
  localparam logic [3:0] I_IRMOV  = 4'h3;
  localparam logic [3:0] I_RMMOV  = 4'h4;
  localparam logic [3:0] I_MRMOV  = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSH   = 4'hA;
  localparam logic [3:0] I_POP    = 4'hB;
  localparam logic [3:0] STAT_AOK = 4'h1;

  localparam logic [W-1:0] EIGHT     = W'(8);
  localparam logic [W-1:0] NEG_EIGHT = ~EIGHT + 1'b1;

  typedef struct packed {
    logic [3:0]   icode;
    logic [3:0]   ifun;
    logic [W-1:0] valA;
    logic [W-1:0] valB;
    logic [W-1:0] valC;
    logic [3:0]   dstE;
    logic [3:0]   dstM;
    logic [3:0]   stat;
  } eReg_t;

  localparam eReg_t BUBBLE = '{
    icode: I_NOP, ifun: 4'h0, valA: '0, valB: '0, valC: '0,
    dstE: REG_NONE, dstM: REG_NONE, stat: STAT_AOK
  };

  eReg_t      eReg;
  eReg_t      dIn;
  logic [2:0] ccReg;     // {ZF, SF, OF}
  logic       setCc;
  logic       cnd;

  assign dIn = '{
    icode: bus.d_icode, ifun: bus.d_ifun, valA: bus.d_valA, valB: bus.d_valB,
    valC: bus.d_valC, dstE: bus.d_dstE, dstM: bus.d_dstM, stat: bus.d_stat
  };

  // Only an OPq updates the flags, and not while an older instruction in M or
  // W is excepting or while E is frozen. Bubble does not gate this: the flags
  // come from the instruction leaving E on this edge.
  assign setCc = (eReg.icode == I_OPQ) && (bus.m_stat == STAT_AOK) &&
                 (bus.w_stat == STAT_AOK) && !bus.e_stall;

  // NOTE: state is updated with non-blocking assignments only, so every
  // register here samples the values from before the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      eReg  <= BUBBLE;
      ccReg <= 3'b100;
    end else begin
      if (bus.e_bubble)     eReg <= BUBBLE;
      else if (!bus.e_stall) eReg <= dIn;

      if (setCc) ccReg <= {(bus.alu_out == '0), bus.alu_out[W-1], bus.alu_of};
    end
  end

  // ALU steering, decoded from the E register contents.
  always_comb begin
    // NOTE: each output gets a default first so no path can infer a latch.
    bus.alu_a   = '0;
    bus.alu_b   = '0;
    bus.alu_fun = 2'd0;
    unique case (eReg.icode)
      I_CMOV, I_OPQ:           bus.alu_a = eReg.valA;
      I_IRMOV, I_RMMOV, I_MRMOV: bus.alu_a = eReg.valC;
      I_CALL, I_PUSH:          bus.alu_a = NEG_EIGHT;
      I_RET, I_POP:            bus.alu_a = EIGHT;
      default:                 bus.alu_a = '0;
    endcase
    unique case (eReg.icode)
      I_RMMOV, I_MRMOV, I_OPQ, I_CALL, I_RET, I_PUSH, I_POP:
               bus.alu_b = eReg.valB;
      default: bus.alu_b = '0;
    endcase
    if (eReg.icode == I_OPQ) bus.alu_fun = eReg.ifun[1:0];
  end

  // Condition evaluation from the registered flags only.
  always_comb begin
    logic zf, sf, of;
    {zf, sf, of} = ccReg;
    cnd = 1'b0;
    if (eReg.icode == I_CMOV || eReg.icode == I_JXX) begin
      unique case (eReg.ifun)
        4'h0:    cnd = 1'b1;
        4'h1:    cnd = (sf ^ of) | zf;
        4'h2:    cnd = sf ^ of;
        4'h3:    cnd = zf;
        4'h4:    cnd = ~zf;
        4'h5:    cnd = ~(sf ^ of);
        4'h6:    cnd = ~(sf ^ of) & ~zf;
        default: cnd = 1'b0;
      endcase
    end
  end

  assign bus.e_cnd   = cnd;
  // A cmov whose condition fails must not write its destination.
  assign bus.e_dstE  = (eReg.icode == I_CMOV && !cnd) ? REG_NONE : eReg.dstE;
  assign bus.e_valE  = bus.alu_out;
  assign bus.e_valA  = eReg.valA;
  assign bus.e_dstM  = eReg.dstM;
  assign bus.e_stat  = eReg.stat;
  assign bus.e_icode = eReg.icode;
  assign bus.cc      = ccReg;

endmodule

// File: tb/tb_y86_exec_ctrl.sv
module tb_y86_exec_ctrl;

  localparam int W = 64;
  localparam logic [63:0] NEG8 = 64'hFFFF_FFFF_FFFF_FFF8;
  localparam logic [63:0] NEG2 = 64'hFFFF_FFFF_FFFF_FFFE;
  localparam logic [63:0] NEG1 = 64'hFFFF_FFFF_FFFF_FFFF;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  y86_exec_ctrl_if #(.W(W)) bus ();

  y86_exec_ctrl #(.W(W), .REG_NONE(4'hF)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic [3:0]  ic, fn;
    logic [63:0] va, vb, vc;
    logic [3:0]  de, dm, st;
    logic        stall, bubble;
    logic [3:0]  ms, ws;
    logic [63:0] alu;
    logic        of;
    logic [3:0]  xIc;
    logic [63:0] xValA;
    logic [3:0]  xDstE, xDstM, xStat;
    logic        xCnd;
    logic [2:0]  xCc;
    logic [63:0] xAluA, xAluB;
    logic [1:0]  xFun;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic addVec(
    input logic [3:0] ic, fn, input logic [63:0] va, vb, vc,
    input logic [3:0] de, dm, st, input logic stall, bubble,
    input logic [3:0] ms, ws, input logic [63:0] alu, input logic of,
    input logic [3:0] xIc, input logic [63:0] xValA,
    input logic [3:0] xDstE, xDstM, xStat, input logic xCnd,
    input logic [2:0] xCc, input logic [63:0] xAluA, xAluB, input logic [1:0] xFun);
    vec_t v;
    v.ic = ic; v.fn = fn; v.va = va; v.vb = vb; v.vc = vc;
    v.de = de; v.dm = dm; v.st = st; v.stall = stall; v.bubble = bubble;
    v.ms = ms; v.ws = ws; v.alu = alu; v.of = of;
    v.xIc = xIc; v.xValA = xValA; v.xDstE = xDstE; v.xDstM = xDstM;
    v.xStat = xStat; v.xCnd = xCnd; v.xCc = xCc; v.xAluA = xAluA;
    v.xAluB = xAluB; v.xFun = xFun;
    vecs.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    bus.d_icode  = v.ic;  bus.d_ifun = v.fn;
    bus.d_valA   = v.va;  bus.d_valB = v.vb; bus.d_valC = v.vc;
    bus.d_dstE   = v.de;  bus.d_dstM = v.dm; bus.d_stat = v.st;
    bus.e_stall  = v.stall; bus.e_bubble = v.bubble;
    bus.m_stat   = v.ms;  bus.w_stat = v.ws;
    bus.alu_out  = v.alu; bus.alu_of = v.of;
  endtask

  task automatic checkState(input string tag, input logic [3:0] ic, input logic [3:0] de,
                            input logic [3:0] dm, input logic [3:0] st,
                            input logic cnd, input logic [2:0] ccv);
    check({tag, " e_icode"}, 64'(bus.e_icode), 64'(ic));
    check({tag, " e_dstE"},  64'(bus.e_dstE),  64'(de));
    check({tag, " e_dstM"},  64'(bus.e_dstM),  64'(dm));
    check({tag, " e_stat"},  64'(bus.e_stat),  64'(st));
    check({tag, " e_cnd"},   64'(bus.e_cnd),   64'(cnd));
    check({tag, " cc"},      64'(bus.cc),      64'(ccv));
  endtask

  initial begin
    vec_t z;
    //      ic    fn    valA     valB     valC      dE    dM    st   stl bub ms  ws  alu   of | eIc   eValA    eDstE eDstM eSt  cnd cc      aluA     aluB     fun
    // subq 5,3 loads; E was nop so no flag update
    addVec(4'h6, 4'h1, 64'h5,   64'h3,   64'h0,    4'h3, 4'hF, 4'h1, 0, 0, 1, 1, 64'h0, 0, 4'h6, 64'h5,   4'h3, 4'hF, 4'h1, 0, 3'b100, 64'h5,   64'h3,   2'd1);
    // ALU returns -2 for subq -> SF; cmovle taken
    addVec(4'h2, 4'h1, 64'h7,   64'h0,   64'h0,    4'h3, 4'hF, 4'h1, 0, 0, 1, 1, NEG2,  0, 4'h2, 64'h7,   4'h3, 4'hF, 4'h1, 1, 3'b010, 64'h7,   64'h0,   2'd0);
    // addq loads
    addVec(4'h6, 4'h0, 64'h1,   64'h2,   64'h0,    4'h4, 4'hF, 4'h1, 0, 0, 1, 1, 64'h0, 0, 4'h6, 64'h1,   4'h4, 4'hF, 4'h1, 0, 3'b010, 64'h1,   64'h2,   2'd0);
    // addq result 3 -> cc=000; cmovle not taken -> dstE squashed
    addVec(4'h2, 4'h1, 64'h9,   64'h0,   64'h0,    4'h3, 4'hF, 4'h1, 0, 0, 1, 1, 64'h3, 0, 4'h2, 64'h9,   4'hF, 4'hF, 4'h1, 0, 3'b000, 64'h9,   64'h0,   2'd0);
    // xorq loads
    addVec(4'h6, 4'h3, 64'h5,   64'h5,   64'h0,    4'h5, 4'hF, 4'h1, 0, 0, 1, 1, 64'h0, 0, 4'h6, 64'h5,   4'h5, 4'hF, 4'h1, 0, 3'b000, 64'h5,   64'h5,   2'd3);
    // xorq result 0 -> cc=100; cmovle taken
    addVec(4'h2, 4'h1, 64'h2,   64'h0,   64'h0,    4'h3, 4'hF, 4'h1, 0, 0, 1, 1, 64'h0, 0, 4'h2, 64'h2,   4'h3, 4'hF, 4'h1, 1, 3'b100, 64'h2,   64'h0,   2'd0);
    // subq loads, then twice with M or W excepting: flags held
    addVec(4'h6, 4'h1, 64'h1,   64'h0,   64'h0,    4'h6, 4'hF, 4'h1, 0, 0, 1, 1, 64'h0, 0, 4'h6, 64'h1,   4'h6, 4'hF, 4'h1, 0, 3'b100, 64'h1,   64'h0,   2'd1);
    addVec(4'h6, 4'h1, 64'h1,   64'h0,   64'h0,    4'h6, 4'hF, 4'h1, 0, 0, 3, 1, NEG1,  0, 4'h6, 64'h1,   4'h6, 4'hF, 4'h1, 0, 3'b100, 64'h1,   64'h0,   2'd1);
    addVec(4'h6, 4'h1, 64'h1,   64'h0,   64'h0,    4'h6, 4'hF, 4'h1, 0, 0, 1, 3, NEG1,  0, 4'h6, 64'h1,   4'h6, 4'hF, 4'h1, 0, 3'b100, 64'h1,   64'h0,   2'd1);
    // M/W clean: flags update to SF,OF; pushq loads (alu_a=-8)
    addVec(4'hA, 4'h0, 64'h55,  64'h100, 64'h0,    4'h4, 4'hF, 4'h1, 0, 0, 1, 1, NEG1,  1, 4'hA, 64'h55,  4'h4, 4'hF, 4'h1, 0, 3'b011, NEG8,    64'h100, 2'd0);
    // stall holds pushq
    addVec(4'h3, 4'h0, 64'h99,  64'h98,  64'h97,   4'h7, 4'h7, 4'h2, 1, 0, 1, 1, 64'h0, 0, 4'hA, 64'h55,  4'h4, 4'hF, 4'h1, 0, 3'b011, NEG8,    64'h100, 2'd0);
    // stall+bubble -> bubble wins
    addVec(4'h3, 4'h0, 64'h99,  64'h98,  64'h97,   4'h7, 4'h7, 4'h2, 1, 1, 1, 1, 64'h0, 0, 4'h1, 64'h0,   4'hF, 4'hF, 4'h1, 0, 3'b011, 64'h0,   64'h0,   2'd0);
    // popq, ret: alu_a=+8
    addVec(4'hB, 4'h0, 64'h100, 64'h200, 64'h0,    4'h4, 4'h2, 4'h1, 0, 0, 1, 1, 64'h0, 0, 4'hB, 64'h100, 4'h4, 4'h2, 4'h1, 0, 3'b011, 64'h8,   64'h200, 2'd0);
    addVec(4'h9, 4'h0, 64'h11,  64'h300, 64'h0,    4'h4, 4'hF, 4'h1, 0, 0, 1, 1, 64'h0, 0, 4'h9, 64'h11,  4'h4, 4'hF, 4'h1, 0, 3'b011, 64'h8,   64'h300, 2'd0);
    // jge with SF=OF=1 -> taken
    addVec(4'h7, 4'h5, 64'h0,   64'h0,   64'h40,   4'hF, 4'hF, 4'h1, 0, 0, 1, 1, 64'h0, 0, 4'h7, 64'h0,   4'hF, 4'hF, 4'h1, 1, 3'b011, 64'h0,   64'h0,   2'd0);
    // irmovq: alu_a=valC; status passthrough
    addVec(4'h3, 4'h0, 64'h0,   64'h0,   64'h1234, 4'h2, 4'hF, 4'h4, 0, 0, 1, 1, 64'h0, 0, 4'h3, 64'h0,   4'h2, 4'hF, 4'h4, 0, 3'b011, 64'h1234,64'h0,   2'd0);
    // jXX with invalid ifun 8 -> 0
    addVec(4'h7, 4'h8, 64'h0,   64'h0,   64'h0,    4'hF, 4'hF, 4'h1, 0, 0, 1, 1, 64'h0, 0, 4'h7, 64'h0,   4'hF, 4'hF, 4'h1, 0, 3'b011, 64'h0,   64'h0,   2'd0);
    // subq loads, then bubble on same edge as its flag update
    addVec(4'h6, 4'h1, 64'h0,   64'h0,   64'h0,    4'h1, 4'hF, 4'h1, 0, 0, 1, 1, 64'h0, 0, 4'h6, 64'h0,   4'h1, 4'hF, 4'h1, 0, 3'b011, 64'h0,   64'h0,   2'd1);
    addVec(4'h6, 4'h1, 64'h0,   64'h0,   64'h0,    4'h1, 4'hF, 4'h1, 0, 1, 1, 1, 64'h0, 0, 4'h1, 64'h0,   4'hF, 4'hF, 4'h1, 0, 3'b100, 64'h0,   64'h0,   2'd0);
    // subq loads; stall blocks its flag update; then released
    addVec(4'h6, 4'h1, 64'h3,   64'h4,   64'h0,    4'h1, 4'hF, 4'h1, 0, 0, 1, 1, 64'h0, 0, 4'h6, 64'h3,   4'h1, 4'hF, 4'h1, 0, 3'b100, 64'h3,   64'h4,   2'd1);
    addVec(4'h6, 4'h1, 64'h3,   64'h4,   64'h0,    4'h1, 4'hF, 4'h1, 1, 0, 1, 1, NEG1,  0, 4'h6, 64'h3,   4'h1, 4'hF, 4'h1, 0, 3'b100, 64'h3,   64'h4,   2'd1);
    addVec(4'h6, 4'h1, 64'h3,   64'h4,   64'h0,    4'h1, 4'hF, 4'h1, 0, 0, 1, 1, NEG1,  0, 4'h6, 64'h3,   4'h1, 4'hF, 4'h1, 0, 3'b010, 64'h3,   64'h4,   2'd1);
    // result 5 -> cc=000; cmovg taken, cmovne taken, cmove not taken
    addVec(4'h2, 4'h6, 64'h77,  64'h0,   64'h0,    4'h8, 4'hF, 4'h1, 0, 0, 1, 1, 64'h5, 0, 4'h2, 64'h77,  4'h8, 4'hF, 4'h1, 1, 3'b000, 64'h77,  64'h0,   2'd0);
    addVec(4'h2, 4'h4, 64'h78,  64'h0,   64'h0,    4'h9, 4'hF, 4'h1, 0, 0, 1, 1, 64'h0, 0, 4'h2, 64'h78,  4'h9, 4'hF, 4'h1, 1, 3'b000, 64'h78,  64'h0,   2'd0);
    addVec(4'h2, 4'h3, 64'h79,  64'h0,   64'h0,    4'h9, 4'hF, 4'h1, 0, 0, 1, 1, 64'h0, 0, 4'h2, 64'h79,  4'hF, 4'hF, 4'h1, 0, 3'b000, 64'h79,  64'h0,   2'd0);

    // Reset with busy-looking inputs.
    z = vecs[0];
    z.alu = NEG1; z.stall = 1'b1;
    drive(z);
    rst_n = 1'b0;
    @(posedge clk); #1;
    checkState("reset", 4'h1, 4'hF, 4'hF, 4'h1, 1'b0, 3'b100);
    check("reset e_valA", bus.e_valA, 64'h0);

    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      drive(vecs[i]);
      @(posedge clk); #1;
      checkState(tag, vecs[i].xIc, vecs[i].xDstE, vecs[i].xDstM, vecs[i].xStat,
                 vecs[i].xCnd, vecs[i].xCc);
      check({tag, " e_valA"},  bus.e_valA, vecs[i].xValA);
      check({tag, " alu_a"},   bus.alu_a,  vecs[i].xAluA);
      check({tag, " alu_b"},   bus.alu_b,  vecs[i].xAluB);
      check({tag, " alu_fun"}, 64'(bus.alu_fun), 64'(vecs[i].xFun));
      check({tag, " e_valE"},  bus.e_valE, vecs[i].alu);
      @(negedge clk);
    end

    // Mid-operation reset: subq in E with flag-update conditions and stall
    // asserted; reset must still win for both E and CC.
    z = vecs[0];
    drive(z);
    @(posedge clk); #1;
    check("midrst pre e_icode", 64'(bus.e_icode), 64'h6);
    @(negedge clk);
    z.alu = NEG1; z.of = 1'b1; z.stall = 1'b1; z.bubble = 1'b0;
    drive(z);
    rst_n = 1'b0;
    @(posedge clk); #1;
    checkState("midrst", 4'h1, 4'hF, 4'hF, 4'h1, 1'b0, 3'b100);
    check("midrst alu_b", bus.alu_b, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
